// File: rtl/instr_issue_ctrl.sv
// Instruction issue queue: buffers fetched {instr, pc} pairs and
// hands them to the decoder one per cycle under issue_ready.
module instr_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr,
  input  logic [31:0]              fetch_pc,
  output logic                     fetch_ready,
  input  logic                     issue_ready,
  output logic                     decode_enable,
  output logic [31:0]              decode_instr,
  output logic [31:0]              decode_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic          push;
  logic          pop;
  logic          in_flush;
  logic          empty;
  logic          full;
  logic [AW:0]   cnt_nxt;

  assign in_flush = (state == FLUSH);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);

  // A pop in the same cycle never opens a slot for the push.
  assign fetch_ready = rst & rdy & ~in_flush & ~full & ~flush;

  assign push = fetch_valid & fetch_ready;
  assign pop  = rdy & ~flush & ~in_flush & ~empty & issue_ready;

  always_comb begin
    cnt_nxt = count;
    if (push && !pop) begin
      cnt_nxt = count + 1'b1;
    end else if (pop && !push) begin
      cnt_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= fetch_instr;
      q_pc[tail]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      decode_enable <= 1'b0;
      decode_instr  <= '0;
      decode_pc     <= '0;
    end else if (!rdy) begin
      decode_enable <= 1'b0;
    end else if (flush) begin
      state         <= FLUSH;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      decode_enable <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head         <= head + 1'b1;
        decode_instr <= q_instr[head];
        decode_pc    <= q_pc[head];
      end
      decode_enable <= pop;
      count         <= cnt_nxt;
      unique case (state)
        IDLE: begin
          if (push) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt_nxt == '0) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl: latency, full/empty, flush,
// streaming with pointer wrap, rdy stall and async reset.
module tb_instr_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        issue_ready;
  logic        decode_enable;
  logic [31:0] decode_instr;
  logic [31:0] decode_pc;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  instr_issue_ctrl #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_instr  (fetch_instr),
    .fetch_pc     (fetch_pc),
    .fetch_ready  (fetch_ready),
    .issue_ready  (issue_ready),
    .decode_enable(decode_enable),
    .decode_instr (decode_instr),
    .decode_pc    (decode_pc),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    fetch_valid = v;
    fetch_instr = ins;
    fetch_pc    = pc;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    issue_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("rst_dec_en", 32'(decode_enable), 32'd0);
    chk("rst_dec_instr", decode_instr, 32'h0);
    chk("rst_dec_pc", decode_pc, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_fetch_ready", 32'(fetch_ready), 32'd1);

    // single instruction latency
    issue_ready = 1'b1;
    offer(1'b1, 32'h00500093, 32'h0);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("lat_cnt1", 32'(count), 32'd1);
    chk("lat_en0", 32'(decode_enable), 32'd0);
    tick();
    chk("lat_en1", 32'(decode_enable), 32'd1);
    chk("lat_instr", decode_instr, 32'h00500093);
    chk("lat_pc", decode_pc, 32'h0);
    chk("lat_cnt0", 32'(count), 32'd0);
    tick();
    chk("lat_en_drop", 32'(decode_enable), 32'd0);
    chk("lat_hold", decode_instr, 32'h00500093);

    // fill to full, then drain in order
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h1000 + 32'(i), 32'(4 * i));
      tick();
    end
    chk("full_cnt", 32'(count), 32'd4);
    offer(1'b1, 32'hdead, 32'h99);
    #1;
    chk("full_ready", 32'(fetch_ready), 32'd0);
    tick();
    chk("full_cnt_hold", 32'(count), 32'd4);
    issue_ready = 1'b1;
    #1;
    chk("full_pop_ready", 32'(fetch_ready), 32'd0);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_en", 32'(decode_enable), 32'd1);
      chk("drain_pc", decode_pc, 32'(4 * i));
      chk("drain_instr", decode_instr, 32'h1000 + 32'(i));
      tick();
    end
    chk("drain_en_end", 32'(decode_enable), 32'd0);
    chk("drain_cnt", 32'(count), 32'd0);

    // flush with simultaneous fetch
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h2000 + 32'(i), 32'h100 + 32'(4 * i));
      tick();
    end
    chk("fl_cnt3", 32'(count), 32'd3);
    flush = 1'b1;
    issue_ready = 1'b1;
    offer(1'b1, 32'h2fff, 32'h1fc);
    #1;
    chk("fl_ready_now", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0;
    offer(1'b1, 32'h3000, 32'h200);
    #1;
    chk("fl_cnt0", 32'(count), 32'd0);
    chk("fl_en0", 32'(decode_enable), 32'd0);
    chk("fl_ready0", 32'(fetch_ready), 32'd0);
    tick();
    chk("fl_ign_cnt", 32'(count), 32'd0);
    chk("fl_ready1", 32'(fetch_ready), 32'd1);
    tick();
    chk("fl_push_cnt", 32'(count), 32'd1);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("fl_pop_en", 32'(decode_enable), 32'd1);
    chk("fl_pop_pc", decode_pc, 32'h200);
    chk("fl_pop_instr", decode_instr, 32'h3000);

    // streaming: one per cycle through the wrap
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'h4000 + 32'(i), 32'h400 + 32'(4 * i));
      tick();
      chk("str_cnt", 32'(count), 32'd1);
      if (i > 0) begin
        chk("str_en", 32'(decode_enable), 32'd1);
        chk("str_pc", decode_pc, 32'h400 + 32'(4 * (i - 1)));
      end
    end
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("str_last_en", 32'(decode_enable), 32'd1);
    chk("str_last_instr", decode_instr, 32'h4009);
    chk("str_last_cnt", 32'(count), 32'd0);
    tick();
    chk("str_end_en", 32'(decode_enable), 32'd0);

    // rdy low stall
    issue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h5000 + 32'(i), 32'h500 + 32'(4 * i));
      tick();
    end
    rdy = 1'b0;
    flush = 1'b1;
    issue_ready = 1'b1;
    offer(1'b1, 32'h5fff, 32'h5fc);
    #1;
    chk("stall_ready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_en", 32'(decode_enable), 32'd0);
      chk("stall_cnt", 32'(count), 32'd2);
    end
    rdy = 1'b1;
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("resume_en0", 32'(decode_enable), 32'd1);
    chk("resume_pc0", decode_pc, 32'h500);
    tick();
    chk("resume_en1", 32'(decode_enable), 32'd1);
    chk("resume_pc1", decode_pc, 32'h504);
    tick();
    chk("resume_end", 32'(decode_enable), 32'd0);
    chk("resume_cnt", 32'(count), 32'd0);

    // async reset mid-operation
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h6000 + 32'(i), 32'h600 + 32'(4 * i));
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("pre_rst_cnt", 32'(count), 32'd2);
    chk("pre_rst_instr", decode_instr, 32'h6000);
    #2 rst = 1'b0;
    #1;
    chk("arst_en", 32'(decode_enable), 32'd0);
    chk("arst_instr", decode_instr, 32'h0);
    chk("arst_pc", decode_pc, 32'h0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_ready", 32'(fetch_ready), 32'd0);
    rst = 1'b1;
    offer(1'b1, 32'h7000, 32'h700);
    #1;
    chk("rel_cnt", 32'(count), 32'd0);
    tick();
    chk("rel_push_cnt", 32'(count), 32'd1);
    offer(1'b0, 32'h0, 32'h0);
    issue_ready = 1'b1;
    tick();
    chk("rel_pop_en", 32'(decode_enable), 32'd1);
    chk("rel_pop_pc", decode_pc, 32'h700);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
